usb_txn_sequencer: RTL and testbench
====================================

Name: usb_txn_sequencer

Overview:
- Host-side read/write transaction controller for the USB host.
- Accepts one 16-bit-address / 64-bit-data read or write request and runs it as USB transactions on a packet engine:
  - Address phase: OUT token plus DATA0 carrying the address.
  - Data phase: OUT plus DATA0 for a write; IN, receive DATA0, then ACK for a read.
- Handles retry, timeout and NAK, and reports pass/fail with read data to the host task layer.

Parameters:
DEV_ADDR, 7'd5, USB device address placed in every token
ADDR_ENDP, 4'd4, endpoint that receives the memory address
DATA_ENDP, 4'd8, endpoint used for data in/out
MAX_TRIES, 8, attempts per phase before the transaction fails
TIMEOUT, 255, cycles to wait for a device response per attempt

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
txn_valid  in  1  request valid
txn_ready  out  1  sequencer idle, request accepted when valid&&ready
txn_write  in  1  1=write, 0=read
txn_addr  in  16  memory address
txn_wdata  in  64  write data
txn_done  out  1  one-cycle completion pulse
txn_ok  out  1  result of last transaction, valid from txn_done until next accept
txn_rdata  out  64  read data, updated only on a successful read
tx_start  out  1  one-cycle pulse: packet engine sends a packet
tx_kind  out  2  TOKEN / DATA / HSHAKE
tx_pid  out  4  PID of the outgoing packet
tx_endp  out  4  token endpoint
tx_payload  out  64  DATA payload
tx_done  in  1  packet engine finished sending
rx_valid  in  1  one-cycle pulse: packet received from device
rx_pid  in  4  received PID
rx_payload  in  64  received DATA payload
rx_err  in  1  CRC/PID/bitstuff error on received packet, qualified by rx_valid

Behaviour:
- Reset (clk edge with rst=1):
  - State IDLE.
  - txn_ready=1. txn_done=0, txn_ok=0, txn_rdata=0.
  - tx_start=0, tx_kind=TOKEN, tx_pid=0, tx_endp=0, tx_payload=0.
  - Counters cleared. No done pulse for an aborted transaction.
- States: IDLE, A_TOK, A_DAT, A_WAIT, B_TOK, B_DAT, B_WAIT, IN_WAIT, IN_HS, DONE.
- IDLE: txn_ready=1 only here. On accept, latch write/addr/wdata, try_cnt=0, go to A_TOK.
- Transmit states (A_TOK, A_DAT, B_TOK, B_DAT, IN_HS):
  - tx_start pulses in the first cycle of the state.
  - tx_* fields are driven stable until tx_done; tx_done advances the state.
- A_TOK: OUT token to DEV_ADDR/ADDR_ENDP.
- A_DAT: DATA0, payload {48'h0, addr}.
- A_WAIT:
  - rx_valid with ACK and !rx_err: go to B_TOK, try_cnt=0.
  - NAK, rx_err, any other PID, or timeout: failed attempt.
- B_TOK:
  - write: OUT token to DATA_ENDP, then B_DAT (DATA0, wdata), then B_WAIT (same rules as A_WAIT, ACK goes to DONE ok=1).
  - read: IN token to DATA_ENDP, then IN_WAIT.
- IN_WAIT:
  - DATA0 with !rx_err: capture rx_payload into rdata, send ACK in IN_HS, then DONE ok=1.
  - rx_err: send NAK in IN_HS, counts as a failed attempt.
  - Other PID or timeout: failed attempt, no handshake sent.
- Failed attempt:
  - try_cnt++.
  - If try_cnt reaches MAX_TRIES: DONE with ok=0.
  - Otherwise restart the current phase at its token state (A_TOK or B_TOK).
- Timeout counter:
  - Cleared on entry to any wait state; increments each wait cycle.
  - Expires when it reaches TIMEOUT without rx_valid.
  - rx_valid in the same cycle as expiry: rx wins.
- rx_valid outside wait states is ignored.
- DONE: txn_done=1 for one cycle, txn_ok set, then IDLE.
- Latency: accept edge to first tx_start is 1 cycle. Final tx_done or ACK to txn_done is 1 cycle.

Decomposition:
- usb_pkg holds:
  - PIDs: OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, ACK 4'b0010, NAK 4'b1010.
  - tx_kind_t enum, state enum, default endpoint constants.
- One sub-module, usb_resp_timer: loadable cycle counter with expire flag, shared by all wait states.

Test Plan:
- Write addr=16'hFFFF, data=64'hFFFF_FFFF_FFFF_FFFF, device ACKs everything -> tx sequence OUT/4, DATA0 0000_0000_0000_FFFF, OUT/8, DATA0 FFFF...F; txn_done with txn_ok=1.
- Read addr=16'hFFFF, device returns DATA0 64'hFFFF_FFFF_FFFF_FFFF -> ACK sent, txn_ok=1, txn_rdata=all ones. Repeat with payload 0 -> rdata=0.
- Read with rx_err on the first 3 DATA0 responses, then clean -> 3 NAKs and 4 IN tokens on DATA_ENDP; ok=1.
- Write where device NAKs the data phase 8 times -> exactly 8 data-phase OUT tokens; txn_done with ok=0; txn_ready back next cycle.
- Device silent in A_WAIT -> retry after exactly TIMEOUT cycles; rx_valid ACK on the expiry cycle -> treated as ACK, no retry.
- rst asserted during B_WAIT -> next cycle IDLE, all outputs at reset values, no txn_done; a new request is accepted afterwards.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB host transaction sequencer:
// PIDs, outgoing packet kinds, sequencer states and default endpoint map.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [6:0] DEF_DEV_ADDR  = 7'd5;
    localparam logic [3:0] DEF_ADDR_ENDP = 4'd4;
    localparam logic [3:0] DEF_DATA_ENDP = 4'd8;
    localparam int         DEF_MAX_TRIES = 8;
    localparam int         DEF_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        KIND_TOKEN  = 2'd0,
        KIND_DATA   = 2'd1,
        KIND_HSHAKE = 2'd2
    } tx_kind_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_A_TOK   = 4'd1,
        S_A_DAT   = 4'd2,
        S_A_WAIT  = 4'd3,
        S_B_TOK   = 4'd4,
        S_B_DAT   = 4'd5,
        S_B_WAIT  = 4'd6,
        S_IN_WAIT = 4'd7,
        S_IN_HS   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == S_A_WAIT) || (s == S_B_WAIT) || (s == S_IN_WAIT);
    endfunction

    function automatic logic is_tx(input state_t s);
        return (s == S_A_TOK) || (s == S_A_DAT) || (s == S_B_TOK) ||
               (s == S_B_DAT) || (s == S_IN_HS);
    endfunction

endpackage

// File: rtl/usb_resp_timer.sv
// Device-response timer shared by all wait states: loaded on wait-state
// entry, counts down each wait cycle, flags expiry on the TIMEOUT-th cycle.
module usb_resp_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Loaded with TIMEOUT-1 so that terminal count zero lands on the last wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/usb_txn_sequencer.sv
// Host-side read/write transaction sequencer: runs an address phase and a
// data phase as USB transactions, with per-phase retry, NAK and timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request
// A_TOK     | sending OUT token to the address endpoint
// A_DAT     | sending DATA0 carrying the memory address
// A_WAIT    | waiting for handshake on the address phase
// B_TOK     | sending OUT (write) or IN (read) token to the data endpoint
// B_DAT     | sending DATA0 carrying the write data
// B_WAIT    | waiting for handshake on the write data phase
// IN_WAIT   | waiting for DATA0 from the device on a read
// IN_HS     | sending ACK (good data) or NAK (corrupted data)
// DONE      | one-cycle completion pulse, then back to IDLE
module usb_txn_sequencer
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter logic [3:0] ADDR_ENDP = DEF_ADDR_ENDP,
    parameter logic [3:0] DATA_ENDP = DEF_DATA_ENDP,
    parameter int         MAX_TRIES = DEF_MAX_TRIES,
    parameter int         TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txn_valid,
    output logic        txn_ready,
    input  logic        txn_write,
    input  logic [15:0] txn_addr,
    input  logic [63:0] txn_wdata,
    output logic        txn_done,
    output logic        txn_ok,
    output logic [63:0] txn_rdata,
    output logic        tx_start,
    output logic [1:0]  tx_kind,
    output logic [3:0]  tx_pid,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_payload,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_payload,
    input  logic        rx_err
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [63:0] TOKEN_PAYLOAD = {57'b0, DEV_ADDR};

    state_t          state, next_state, prev_state;
    logic            wr_q;
    logic [15:0]     addr_q;
    logic [63:0]     wdata_q;
    logic [63:0]     rdata_q;
    logic [TW-1:0]   try_cnt, try_next;
    logic            hs_ack, hs_next;
    logic            ok_q, ok_next;
    logic            accept, capture, fail;
    logic            tmr_load, tmr_run, tmr_expired;
    tx_kind_t        kind_c;
    logic [3:0]      pid_c, endp_c;
    logic [63:0]     payload_c;

    usb_resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_state <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            try_cnt    <= '0;
            hs_ack     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            state      <= next_state;
            prev_state <= state;
            try_cnt    <= try_next;
            hs_ack     <= hs_next;
            ok_q       <= ok_next;
            if (accept) begin
                wr_q    <= txn_write;
                addr_q  <= txn_addr;
                wdata_q <= txn_wdata;
            end
            if (capture) begin
                rdata_q <= rx_payload;
            end
        end
    end

    always_comb begin
        next_state = state;
        try_next   = try_cnt;
        hs_next    = hs_ack;
        ok_next    = ok_q;
        accept     = 1'b0;
        capture    = 1'b0;
        fail       = 1'b0;
        kind_c     = KIND_TOKEN;
        pid_c      = 4'h0;
        endp_c     = 4'h0;
        payload_c  = '0;

        unique case (state)
            S_IDLE: begin
                if (txn_valid) begin
                    accept     = 1'b1;
                    try_next   = '0;
                    ok_next    = 1'b0;
                    next_state = S_A_TOK;
                end
            end
            S_A_TOK: begin
                pid_c     = PID_OUT;
                endp_c    = ADDR_ENDP;
                payload_c = TOKEN_PAYLOAD;
                if (tx_done) next_state = S_A_DAT;
            end
            S_A_DAT: begin
                kind_c    = KIND_DATA;
                pid_c     = PID_DATA0;
                payload_c = {48'h0, addr_q};
                if (tx_done) next_state = S_A_WAIT;
            end
            S_A_WAIT: begin
                if (rx_valid) begin
                    if ((rx_pid == PID_ACK) && !rx_err) begin
                        try_next   = '0;
                        next_state = S_B_TOK;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr_expired) begin
                    fail = 1'b1;
                end
            end
            S_B_TOK: begin
                pid_c     = wr_q ? PID_OUT : PID_IN;
                endp_c    = DATA_ENDP;
                payload_c = TOKEN_PAYLOAD;
                if (tx_done) next_state = wr_q ? S_B_DAT : S_IN_WAIT;
            end
            S_B_DAT: begin
                kind_c    = KIND_DATA;
                pid_c     = PID_DATA0;
                payload_c = wdata_q;
                if (tx_done) next_state = S_B_WAIT;
            end
            S_B_WAIT: begin
                if (rx_valid) begin
                    if ((rx_pid == PID_ACK) && !rx_err) begin
                        ok_next    = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr_expired) begin
                    fail = 1'b1;
                end
            end
            S_IN_WAIT: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        hs_next    = 1'b0;
                        next_state = S_IN_HS;
                    end else if (rx_pid == PID_DATA0) begin
                        capture    = 1'b1;
                        hs_next    = 1'b1;
                        next_state = S_IN_HS;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr_expired) begin
                    fail = 1'b1;
                end
            end
            S_IN_HS: begin
                kind_c = KIND_HSHAKE;
                pid_c  = hs_ack ? PID_ACK : PID_NAK;
                // A NAK we send for corrupted data is itself the failed attempt.
                if (tx_done) begin
                    if (hs_ack) begin
                        ok_next    = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if (fail) begin
            if (try_cnt == TW'(MAX_TRIES - 1)) begin
                ok_next    = 1'b0;
                next_state = S_DONE;
            end else begin
                try_next   = try_cnt + 1'b1;
                next_state = (state == S_A_WAIT) ? S_A_TOK : S_B_TOK;
            end
        end
    end

    // Every wait state is entered from a transmit state, never from another wait state.
    assign tmr_load = is_wait(next_state) && !is_wait(state);
    assign tmr_run  = is_wait(state);

    assign txn_ready  = (state == S_IDLE);
    assign txn_done   = (state == S_DONE);
    assign txn_ok     = ok_q;
    assign txn_rdata  = rdata_q;
    assign tx_start   = is_tx(state) && (state != prev_state);
    assign tx_kind    = kind_c;
    assign tx_pid     = pid_c;
    assign tx_endp    = endp_c;
    assign tx_payload = payload_c;

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Directed bench for usb_txn_sequencer: a scripted device/packet-engine model
// answers each wait phase; each scenario task checks the logged packets.
module tb_usb_txn_sequencer;

    localparam int T = 255;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011;
    localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010;
    localparam int R_ACK = 0, R_NAK = 1, R_DATA = 2, R_ERR = 3, R_SILENT = 4, R_EXP = 5;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] A5   = 64'hA5A5_5A5A_0F0F_F0F0;

    logic        clk = 1'b0, rst = 1'b1;
    logic        txn_valid = 1'b0, txn_ready, txn_write = 1'b0;
    logic [15:0] txn_addr = '0;
    logic [63:0] txn_wdata = '0, txn_rdata, tx_payload, rx_payload = '0;
    logic        txn_done, txn_ok, tx_start, tx_done = 1'b0, rx_valid = 1'b0, rx_err = 1'b0;
    logic [1:0]  tx_kind;
    logic [3:0]  tx_pid, tx_endp, rx_pid = '0;

    usb_txn_sequencer dut (
        .clk(clk), .rst(rst), .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_write(txn_write), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
        .txn_done(txn_done), .txn_ok(txn_ok), .txn_rdata(txn_rdata),
        .tx_start(tx_start), .tx_kind(tx_kind), .tx_pid(tx_pid), .tx_endp(tx_endp),
        .tx_payload(tx_payload), .tx_done(tx_done), .rx_valid(rx_valid),
        .rx_pid(rx_pid), .rx_payload(rx_payload), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;

    int          rs_code [0:31];
    logic [63:0] rs_data [0:31];
    int          rs_n, rs_idx;

    logic [1:0]  pk_kind [0:63];
    logic [3:0]  pk_pid [0:63], pk_endp [0:63];
    logic [63:0] pk_pay [0:63];
    int          pk_start [0:63], pk_donec [0:63];
    int          pk_n, n_done;

    bit          got_done, done_ok, aborted;
    logic [63:0] done_rdata;
    int          done_cyc, last_evt, accept_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic add_resp(input int code, input logic [63:0] d);
        rs_code[rs_n] = code;
        rs_data[rs_n] = d;
        rs_n++;
    endtask

    // Presents one request and plays packet engine + device until txn_done,
    // an optional reset in the data-phase wait, or the cycle budget runs out.
    task automatic run_txn(input bit wr, input logic [15:0] a, input logic [63:0] d, input bit abort);
        int pend, wcyc, rat, code;
        logic [63:0] cdat;
        pend = -1; wcyc = -1; rat = 0; code = R_SILENT; cdat = '0;
        pk_n = 0; n_done = 0; rs_idx = 0; got_done = 0; aborted = 0;
        done_ok = 0; done_rdata = '0; done_cyc = 0; last_evt = 0;
        txn_valid = 1'b1; txn_write = wr; txn_addr = a; txn_wdata = d;
        accept_cyc = cyc;
        for (int n = 0; n < 4000; n++) begin
            tick();
            txn_valid = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
            rx_pid = '0; rx_payload = '0;
            if (txn_done === 1'b1) begin
                got_done = 1; done_ok = txn_ok; done_rdata = txn_rdata; done_cyc = cyc;
                break;
            end
            if (abort && n_done == 4 && cyc == pk_donec[3] + 2) begin
                rst = 1'b1; aborted = 1;
                break;
            end
            if (wcyc >= 0) begin
                if (wcyc == rat) begin
                    rx_valid = 1'b1; last_evt = cyc; wcyc = -1;
                    case (code)
                        R_NAK:   rx_pid = P_NAK;
                        R_DATA:  begin rx_pid = P_D0; rx_payload = cdat; end
                        R_ERR:   begin rx_pid = P_D0; rx_payload = cdat; rx_err = 1'b1; end
                        default: rx_pid = P_ACK;
                    endcase
                end else begin
                    wcyc++;
                end
            end
            if (tx_start === 1'b1) begin
                if (pk_n < 64) begin
                    pk_kind[pk_n] = tx_kind; pk_pid[pk_n] = tx_pid; pk_endp[pk_n] = tx_endp;
                    pk_pay[pk_n] = tx_payload; pk_start[pk_n] = cyc;
                    pk_n++;
                end
                pend = 1;
            end else if (pend == 1 && pk_n > 0) begin
                tx_done = 1'b1; pend = -1; pk_donec[pk_n-1] = cyc; n_done++; last_evt = cyc;
                if (pk_kind[pk_n-1] == 2'd1 || (pk_kind[pk_n-1] == 2'd0 && pk_pid[pk_n-1] == P_IN)) begin
                    if (rs_idx < rs_n) begin
                        code = rs_code[rs_idx]; cdat = rs_data[rs_idx]; rs_idx++;
                    end else begin
                        code = R_SILENT;
                    end
                    if (code == R_SILENT) wcyc = -1;
                    else begin
                        wcyc = 0;
                        rat = (code == R_EXP) ? T - 1 : 2;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++; if (txn_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0h exp 1", txn_ready); end
        vectors++; if ({txn_done, txn_ok, tx_start} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {txn_done, txn_ok, tx_start}); end
        vectors++; if (txn_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", txn_rdata); end
        vectors++; if ({tx_kind, tx_pid, tx_endp, tx_payload} !== 74'h0) begin miscompares++; $display("FAIL reset_tx got %h/%h/%h/%h exp all 0", tx_kind, tx_pid, tx_endp, tx_payload); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_ack();
        rs_n = 0; add_resp(R_ACK, 0); add_resp(R_ACK, 0);
        run_txn(1'b1, 16'hFFFF, ONES, 1'b0);
        vectors++; if ({got_done, done_ok} !== 2'b11) begin miscompares++; $display("FAIL wr_done_ok got %b exp 11", {got_done, done_ok}); end
        vectors++; if (pk_n !== 4) begin miscompares++; $display("FAIL wr_pkt_count got %0d exp 4", pk_n); end
        vectors++; if (pk_start[0] - accept_cyc !== 1) begin miscompares++; $display("FAIL wr_start_latency got %0d exp 1", pk_start[0] - accept_cyc); end
        vectors++; if ({pk_kind[0], pk_pid[0], pk_endp[0], pk_pay[0]} !== {2'd0, P_OUT, 4'd4, 64'd5}) begin miscompares++; $display("FAIL wr_pkt0 got %h/%h/%h/%h exp 0/1/4/5", pk_kind[0], pk_pid[0], pk_endp[0], pk_pay[0]); end
        vectors++; if ({pk_kind[1], pk_pid[1], pk_pay[1]} !== {2'd1, P_D0, 64'h0000_0000_0000_FFFF}) begin miscompares++; $display("FAIL wr_pkt1 got %h/%h/%h exp 1/3/ffff", pk_kind[1], pk_pid[1], pk_pay[1]); end
        vectors++; if ({pk_kind[2], pk_pid[2], pk_endp[2], pk_pay[2]} !== {2'd0, P_OUT, 4'd8, 64'd5}) begin miscompares++; $display("FAIL wr_pkt2 got %h/%h/%h/%h exp 0/1/8/5", pk_kind[2], pk_pid[2], pk_endp[2], pk_pay[2]); end
        vectors++; if ({pk_kind[3], pk_pid[3], pk_pay[3]} !== {2'd1, P_D0, ONES}) begin miscompares++; $display("FAIL wr_pkt3 got %h/%h/%h exp 1/3/ones", pk_kind[3], pk_pid[3], pk_pay[3]); end
        vectors++; if (done_cyc - last_evt !== 1) begin miscompares++; $display("FAIL wr_done_latency got %0d exp 1", done_cyc - last_evt); end
        tick();
        vectors++; if (txn_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_after got %0h exp 1", txn_ready); end
    endtask

    task automatic test_read(input logic [63:0] rd);
        rs_n = 0; add_resp(R_ACK, 0); add_resp(R_DATA, rd);
        run_txn(1'b0, 16'hFFFF, 64'h0, 1'b0);
        vectors++; if ({got_done, done_ok} !== 2'b11) begin miscompares++; $display("FAIL rd_done_ok got %b exp 11", {got_done, done_ok}); end
        vectors++; if (pk_n !== 4) begin miscompares++; $display("FAIL rd_pkt_count got %0d exp 4", pk_n); end
        vectors++; if ({pk_kind[2], pk_pid[2], pk_endp[2]} !== {2'd0, P_IN, 4'd8}) begin miscompares++; $display("FAIL rd_in_token got %h/%h/%h exp 0/9/8", pk_kind[2], pk_pid[2], pk_endp[2]); end
        vectors++; if ({pk_kind[3], pk_pid[3]} !== {2'd2, P_ACK}) begin miscompares++; $display("FAIL rd_ack_hs got %h/%h exp 2/2", pk_kind[3], pk_pid[3]); end
        vectors++; if (done_rdata !== rd) begin miscompares++; $display("FAIL rd_rdata got %h exp %h", done_rdata, rd); end
        vectors++; if (done_cyc - last_evt !== 1) begin miscompares++; $display("FAIL rd_done_latency got %0d exp 1", done_cyc - last_evt); end
        tick();
    endtask

    task automatic test_read_retry();
        int n_in, n_nak, n_ack;
        rs_n = 0; add_resp(R_ACK, 0);
        for (int i = 0; i < 3; i++) add_resp(R_ERR, 64'h0BAD_0BAD_0BAD_0BAD);
        add_resp(R_DATA, A5);
        run_txn(1'b0, 16'h00C3, 64'h0, 1'b0);
        n_in = 0; n_nak = 0; n_ack = 0;
        for (int i = 0; i < pk_n; i++) begin
            if (pk_kind[i] == 2'd0 && pk_pid[i] == P_IN && pk_endp[i] == 4'd8) n_in++;
            if (pk_kind[i] == 2'd2 && pk_pid[i] == P_NAK) n_nak++;
            if (pk_kind[i] == 2'd2 && pk_pid[i] == P_ACK) n_ack++;
        end
        vectors++; if (n_in !== 4) begin miscompares++; $display("FAIL rr_in_tokens got %0d exp 4", n_in); end
        vectors++; if (n_nak !== 3) begin miscompares++; $display("FAIL rr_naks got %0d exp 3", n_nak); end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL rr_acks got %0d exp 1", n_ack); end
        vectors++; if ({got_done, done_ok} !== 2'b11) begin miscompares++; $display("FAIL rr_done_ok got %b exp 11", {got_done, done_ok}); end
        vectors++; if (done_rdata !== A5) begin miscompares++; $display("FAIL rr_rdata got %h exp %h", done_rdata, A5); end
        tick();
    endtask

    task automatic test_write_nak();
        int n_out8;
        rs_n = 0; add_resp(R_ACK, 0);
        for (int i = 0; i < 8; i++) add_resp(R_NAK, 0);
        run_txn(1'b1, 16'h1234, 64'h1111_2222_3333_4444, 1'b0);
        n_out8 = 0;
        for (int i = 0; i < pk_n; i++)
            if (pk_kind[i] == 2'd0 && pk_pid[i] == P_OUT && pk_endp[i] == 4'd8) n_out8++;
        vectors++; if (n_out8 !== 8) begin miscompares++; $display("FAIL nak_out_tokens got %0d exp 8", n_out8); end
        vectors++; if (pk_n !== 18) begin miscompares++; $display("FAIL nak_pkt_count got %0d exp 18", pk_n); end
        vectors++; if ({got_done, done_ok} !== 2'b10) begin miscompares++; $display("FAIL nak_done_ok got %b exp 10", {got_done, done_ok}); end
        vectors++; if (done_rdata !== A5) begin miscompares++; $display("FAIL nak_rdata_kept got %h exp %h", done_rdata, A5); end
        tick();
        vectors++; if (txn_ready !== 1'b1) begin miscompares++; $display("FAIL nak_ready_after got %0h exp 1", txn_ready); end
    endtask

    task automatic test_timeout();
        rs_n = 0; add_resp(R_SILENT, 0); add_resp(R_ACK, 0); add_resp(R_ACK, 0);
        run_txn(1'b1, 16'h0001, 64'h0123_4567_89AB_CDEF, 1'b0);
        vectors++; if (pk_n !== 6) begin miscompares++; $display("FAIL to_pkt_count got %0d exp 6", pk_n); end
        // T wait cycles after the DATA0 tx_done, then the retried token starts.
        vectors++; if (pk_start[2] - pk_donec[1] !== T + 1) begin miscompares++; $display("FAIL to_retry_delay got %0d exp %0d", pk_start[2] - pk_donec[1], T + 1); end
        vectors++; if ({pk_pid[2], pk_endp[2]} !== {P_OUT, 4'd4}) begin miscompares++; $display("FAIL to_retry_token got %h/%h exp 1/4", pk_pid[2], pk_endp[2]); end
        vectors++; if ({got_done, done_ok} !== 2'b11) begin miscompares++; $display("FAIL to_done_ok got %b exp 11", {got_done, done_ok}); end
        tick();
    endtask

    task automatic test_expiry_race();
        rs_n = 0; add_resp(R_EXP, 0); add_resp(R_ACK, 0);
        run_txn(1'b1, 16'h8000, 64'h5555_AAAA_5555_AAAA, 1'b0);
        vectors++; if (pk_n !== 4) begin miscompares++; $display("FAIL race_pkt_count got %0d exp 4", pk_n); end
        vectors++; if ({pk_pid[2], pk_endp[2]} !== {P_OUT, 4'd8}) begin miscompares++; $display("FAIL race_next_token got %h/%h exp 1/8", pk_pid[2], pk_endp[2]); end
        vectors++; if ({got_done, done_ok} !== 2'b11) begin miscompares++; $display("FAIL race_done_ok got %b exp 11", {got_done, done_ok}); end
        tick();
    endtask

    task automatic test_reset_midway();
        bit saw_done;
        rs_n = 0; add_resp(R_ACK, 0); add_resp(R_SILENT, 0);
        run_txn(1'b1, 16'h0042, 64'hCAFE_F00D_CAFE_F00D, 1'b1);
        vectors++; if (aborted !== 1'b1) begin miscompares++; $display("FAIL mid_reached_bwait got %0d exp 1", aborted); end
        tick();
        vectors++; if ({txn_ready, txn_done, txn_ok, tx_start} !== 4'b1000) begin miscompares++; $display("FAIL mid_flags got %b exp 1000", {txn_ready, txn_done, txn_ok, tx_start}); end
        vectors++; if (txn_rdata !== 64'h0) begin miscompares++; $display("FAIL mid_rdata got %h exp 0", txn_rdata); end
        vectors++; if ({tx_kind, tx_pid, tx_endp, tx_payload} !== 74'h0) begin miscompares++; $display("FAIL mid_tx got %h/%h/%h/%h exp all 0", tx_kind, tx_pid, tx_endp, tx_payload); end
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (txn_done === 1'b1) saw_done = 1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL mid_no_done got %0d exp 0", saw_done); end
        rs_n = 0; add_resp(R_ACK, 0); add_resp(R_DATA, 64'hDEAD_BEEF_0000_1111);
        run_txn(1'b0, 16'h0042, 64'h0, 1'b0);
        vectors++; if ({got_done, done_ok} !== 2'b11) begin miscompares++; $display("FAIL mid_new_ok got %b exp 11", {got_done, done_ok}); end
        vectors++; if (done_rdata !== 64'hDEAD_BEEF_0000_1111) begin miscompares++; $display("FAIL mid_new_rdata got %h exp deadbeef00001111", done_rdata); end
        tick();
    endtask

    initial begin
        rs_n = 0; rs_idx = 0; pk_n = 0; n_done = 0;
        test_reset();
        test_write_ack();
        test_read(ONES);
        test_read(64'h0);
        test_read_retry();
        test_write_nak();
        test_timeout();
        test_expiry_race();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
